// File: rtl/burst_memory_pkg.sv
// Shared types for the burst memory: controller states and the default word width.
package burst_memory_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_XFER = 2'd3
  } state_e;

endpackage

// File: rtl/burst_mem_array.sv
// DEPTH x DATA_WIDTH storage with one synchronous write port and one asynchronous read port.
module burst_mem_array
  import burst_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; the controller's INIT sweep zero-fills it one word per cycle.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/burst_memory.sv
// Wait-stated burst RAM on a shared tri-state bus: INIT zero-fill, then single or
// wrapping multi-beat reads/writes with busy/ready/err status.
module burst_memory
  import burst_memory_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int WAIT_STATES = 1,
  parameter int BLEN_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CS,
  input  logic                  WE,
  input  logic                  OE,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [BLEN_WIDTH-1:0] burst_len,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  localparam int BEAT_W = BLEN_WIDTH + 1;
  localparam int WCNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [WCNT_W-1:0]     WCNT_LOAD = (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BEAT_W-1:0]       beats_q, beats_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;

  logic                    req_one;
  logic                    addr_ok;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    drive_en;

  assign req_one = WE ^ OE;
  assign addr_ok = {1'b0, address} < DEPTH_LIM;

  // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    wcnt_d  = wcnt_q;
    write_d = write_q;
    err_d   = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (CS) begin
          if (req_one && addr_ok) begin
            write_d = WE;
            addr_d  = address;
            beats_d = {1'b0, burst_len} + BEAT_W'(1);
            wcnt_d  = WCNT_LOAD;
            state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_XFER;
          end else if (WE || OE) begin
            err_d = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (!CS) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (wcnt_q == '0) begin
          state_d = ST_XFER;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end

      ST_XFER: begin
        if (!CS) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          beats_d = beats_q - 1'b1;
          if (beats_q == BEAT_W'(1)) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      addr_q  <= '0;
      beats_q <= '0;
      wcnt_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      wcnt_q  <= wcnt_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // A write beat lands only if the burst is still selected and not being reset at this edge.
  assign mem_we    = !reset && ((state_q == ST_INIT) || (state_q == ST_XFER && write_q && CS));
  assign mem_waddr = (state_q == ST_INIT) ? ptr_q : addr_q;
  assign mem_wdata = (state_q == ST_INIT) ? '0 : data;

  burst_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (addr_q),
    .rdata_o (mem_rdata)
  );

  assign drive_en = (state_q == ST_XFER) && !write_q;
  assign data     = drive_en ? mem_rdata : 'z;
  assign ready    = (state_q == ST_XFER);
  assign busy     = (state_q != ST_IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_burst_memory.sv
// Randomized scoreboard bench for burst_memory: a reference array model predicts every
// beat, a negedge monitor pops and compares whenever ready is high.
module tb_burst_memory;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int WS    = 2;
  localparam int BLW   = 3;

  typedef struct {
    bit       rd;
    logic [7:0] val;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs, we, oe;
  logic [AW-1:0] addr;
  logic [BLW-1:0] blen;
  logic          tb_drive;
  logic [DW-1:0] tb_wdata;
  wire  [DW-1:0] data;
  logic          ready, busy, err;

  logic          cs12, we12, oe12;
  logic [3:0]    addr12;
  logic [BLW-1:0] blen12;
  wire  [DW-1:0] data12;
  logic          ready12, busy12, err12;

  int            n_checks = 0;
  int            n_errors = 0;
  beat_t         exp_q[$];
  logic [7:0]    wq[$];
  logic [7:0]    model_mem [DEPTH];

  assign data = tb_drive ? tb_wdata : 'z;

  always #5 clk = ~clk;

  burst_memory #(
    .DATA_WIDTH (DW), .DEPTH (DEPTH), .ADDR_WIDTH (AW), .WAIT_STATES (WS), .BLEN_WIDTH (BLW)
  ) u_dut (
    .clk (clk), .reset (reset), .CS (cs), .WE (we), .OE (oe), .address (addr),
    .burst_len (blen), .data (data), .ready (ready), .busy (busy), .err (err)
  );

  burst_memory #(
    .DATA_WIDTH (DW), .DEPTH (12), .ADDR_WIDTH (4), .WAIT_STATES (WS), .BLEN_WIDTH (BLW)
  ) u_dut12 (
    .clk (clk), .reset (reset), .CS (cs12), .WE (we12), .OE (oe12), .address (addr12),
    .burst_len (blen12), .data (data12), .ready (ready12), .busy (busy12), .err (err12)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ready cycle must match the oldest predicted beat.
  always @(negedge clk) begin
    beat_t b;
    if (ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_beat: ready high with no beat predicted at %0t", $time);
      end else begin
        b = exp_q.pop_front();
        if (b.rd) check("read_data", 32'(data), 32'(b.val));
        else      check("write_bus", 32'(data), 32'(b.val));
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
  endtask

  task automatic reset_and_init();
    reset = 1'b1;
    cs = 1'b0; we = 1'b0; oe = 1'b0; tb_drive = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_ready", 32'(ready), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_err", 32'(err), 0);
    reset = 1'b0;
    begin
      int cnt = 0;
      while (busy && cnt < 20) begin
        cnt++;
        @(posedge clk); #1;
      end
      check("init_busy_cycles", 32'(cnt), 8);
    end
    clear_model();
  endtask

  // One transaction; abort_at >= 0 drops CS during that beat.
  task automatic burst(input bit wr, input int a, input int bl, input int abort_at);
    int n;
    int cur;
    logic [7:0] v;
    n   = bl + 1;
    cur = a;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 0);
    cs = 1'b1; we = wr; oe = !wr;
    addr = AW'(a); blen = BLW'(bl);
    @(posedge clk); #1;
    check("accept_busy", 32'(busy), 1);
    we = 1'b0; oe = 1'b0;
    for (int w = 0; w < WS; w++) begin
      check("wait_ready", 32'(ready), 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < n; i++) begin
      check("beat_ready", 32'(ready), 1);
      if (wr) begin
        if (wq.size() > 0) v = wq.pop_front();
        else               v = 8'($urandom);
        tb_wdata = v;
        tb_drive = 1'b1;
        exp_q.push_back('{1'b0, v});
      end else begin
        exp_q.push_back('{1'b1, model_mem[cur]});
      end
      if (i == abort_at) begin
        cs = 1'b0;
        @(posedge clk); #1;
        tb_drive = 1'b0;
        check("abort_err", 32'(err), 1);
        check("abort_busy", 32'(busy), 0);
        @(posedge clk); #1;
        check("abort_err_clear", 32'(err), 0);
        return;
      end
      if (wr) model_mem[cur] = v;
      cur = (cur + 1) % DEPTH;
      @(posedge clk); #1;
    end
    tb_drive = 1'b0;
    cs = 1'b0;
    check("end_busy", 32'(busy), 0);
    check("end_ready", 32'(ready), 0);
  endtask

  task automatic illegal_both(input int a);
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b1; oe = 1'b1; addr = AW'(a); blen = '0;
    @(posedge clk); #1;
    check("illegal_err", 32'(err), 1);
    check("illegal_busy", 32'(busy), 0);
    cs = 1'b0; we = 1'b0; oe = 1'b0;
    @(posedge clk); #1;
    check("illegal_err_clear", 32'(err), 0);
    check("illegal_busy_after", 32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cs12 = 1'b0; we12 = 1'b0; oe12 = 1'b0; addr12 = '0; blen12 = '0;
    addr = '0; blen = '0; tb_wdata = '0;
    reset_and_init();

    // Out-of-range address on the 12-word instance, then a legal read of its last word.
    repeat (6) @(posedge clk);
    #1;
    cs12 = 1'b1; oe12 = 1'b1; addr12 = 4'd12;
    @(posedge clk); #1;
    check("d12_range_err", 32'(err12), 1);
    check("d12_range_busy", 32'(busy12), 0);
    cs12 = 1'b0; oe12 = 1'b0;
    @(posedge clk); #1;
    check("d12_err_clear", 32'(err12), 0);
    cs12 = 1'b1; oe12 = 1'b1; addr12 = 4'd11; blen12 = '0;
    @(posedge clk); #1;
    check("d12_accept_busy", 32'(busy12), 1);
    oe12 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("d12_ready", 32'(ready12), 1);
    check("d12_read", 32'(data12), 0);
    @(posedge clk); #1;
    check("d12_end_busy", 32'(busy12), 0);
    cs12 = 1'b0;

    for (int a = 0; a < DEPTH; a++) burst(1'b0, a, 0, -1);

    wq.push_back(8'hA5);
    burst(1'b1, 3, 0, -1);
    burst(1'b0, 3, 0, -1);
    burst(1'b0, 2, 0, -1);
    burst(1'b0, 4, 0, -1);

    wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33); wq.push_back(8'h44);
    burst(1'b1, 6, 3, -1);
    burst(1'b0, 6, 3, -1);

    illegal_both(5);
    burst(1'b0, 0, 7, -1);

    burst(1'b1, 0, 3, 2);
    burst(1'b0, 0, 3, -1);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 9) == 0) illegal_both(int'($urandom_range(0, DEPTH - 1)));
      else burst(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                 int'($urandom_range(0, 7)), -1);
    end
    burst(1'b0, 0, 7, -1);

    // Reset in the middle of a read burst.
    @(posedge clk); #1;
    cs = 1'b1; oe = 1'b1; we = 1'b0; addr = 3'd0; blen = 3'd7;
    @(posedge clk); #1;
    oe = 1'b0;
    repeat (WS) begin
      @(posedge clk); #1;
    end
    exp_q.push_back('{1'b1, model_mem[0]});
    @(posedge clk); #1;
    exp_q.push_back('{1'b1, model_mem[1]});
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 32'(ready), 0);
    check("midrst_busy", 32'(busy), 1);
    cs = 1'b0;
    reset_and_init();
    burst(1'b0, 0, 7, -1);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
